sync_debounce_bank: RTL and testbench

- Parametrised successor to the single-bit D flip-flop used for PWM control inputs.
- Provides CH independent channels. Each channel has a SYNC_STAGES-deep flip-flop synchroniser, a clock-enable-gated debounce counter, and registered rise/fall strobes.
- Sits between asynchronous board inputs (buttons, switches, external enables) and the PWM duty/mode control logic.
- All outputs are clean, glitch-free, single-clock-domain signals.

---
 rtl/sync_db_pkg.sv | 22 ++
 rtl/sync_db_ch.sv | 80 ++++++++
 rtl/sync_debounce_bank.sv | 41 ++++
 tb/tb_sync_debounce_bank.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sync_db_pkg.sv
// Shared helpers and defaults for the synchronise-and-debounce input bank.
package sync_db_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 8;

    // Smallest r with 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Counter must hold 0..DB_CYCLES-1; sized for DB_CYCLES+1 states for headroom.
    function automatic int cnt_w(input int db_cycles);
        return clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_db_ch.sv
// One input channel: flop synchroniser, ce-gated debounce counter, registered edge strobes.
module sync_db_ch
    import sync_db_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   DB_CYCLES   = DEF_DB_CYCLES,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic ck,
    input  logic rst_n,
    input  logic ce,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pend
);

    localparam int            CW       = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sync_db_ch: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("sync_db_ch: DB_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] s_q, s_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sy;

    assign sy = s_q[SYNC_STAGES-1];

    always_comb begin
        s_d     = {s_q[SYNC_STAGES-2:0], d};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // Any agreement with the current level throws away a partial qualification.
        if (sy == level_q) begin
            cnt_d = '0;
        end else if (ce) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sy;
                cnt_d   = '0;
                rise_d  = sy;
                fall_d  = ~sy;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= {SYNC_STAGES{RST_VAL}};
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign pend  = (cnt_q != '0);

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of CH independent synchronise-and-debounce channels for asynchronous board inputs.
module sync_debounce_bank
    import sync_db_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int          DB_CYCLES   = DEF_DB_CYCLES,
    parameter logic [CH-1:0] RST_VAL   = '0
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          ce,
    input  logic [CH-1:0] d,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] pend
);

    if (CH < 1) begin : g_bad_ch
        $error("sync_debounce_bank: CH must be >= 1");
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        sync_db_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RST_VAL     (RST_VAL[i])
        ) u_ch (
            .ck    (ck),
            .rst_n (rst_n),
            .ce    (ce),
            .d     (d[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .pend  (pend[i])
        );
    end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench: vector table for step/glitch behaviour plus hand sequences for reset, ce gating, bounce and independence.
module tb_sync_debounce_bank;

    logic       ck = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic [1:0] d_a = 2'b00;
    logic [1:0] d_b = 2'b10;
    logic [1:0] lvl_a, rise_a, fall_a, pend_a;
    logic [1:0] lvl_b, rise_b, fall_b, pend_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 ck = ~ck;

    sync_debounce_bank #(.CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .RST_VAL(2'b00)) dut_a (
        .ck(ck), .rst_n(rst_n), .ce(ce), .d(d_a),
        .level(lvl_a), .rise(rise_a), .fall(fall_a), .pend(pend_a)
    );

    sync_debounce_bank #(.CH(2), .SYNC_STAGES(2), .DB_CYCLES(4), .RST_VAL(2'b10)) dut_b (
        .ck(ck), .rst_n(rst_n), .ce(ce), .d(d_b),
        .level(lvl_b), .rise(rise_b), .fall(fall_b), .pend(pend_b)
    );

    typedef struct packed {
        logic [1:0] d;
        logic       ce;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] pend;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got lvl/rise/fall/pend=%b want %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        d_a   = 2'b00;
        d_b   = 2'b10;
        ce    = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r_cnt;
        logic [1:0] el, er, ef, ep;

        //            d      ce    lvl    rise   fall   pend
        tbl[0]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[3]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[4]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[5]  = '{2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00};
        tbl[6]  = '{2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[7]  = '{2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[9]  = '{2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[10] = '{2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[11] = '{2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[12] = '{2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00};
        tbl[14] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        // 3-sample glitch on ch1; the count is frozen by ce=0, then cleared by sy returning.
        tbl[15] = '{2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[16] = '{2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[17] = '{2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[18] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[19] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[20] = '{2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[21] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_a", {lvl_a, rise_a, fall_a, pend_a}, 8'b00_00_00_00);
        chk("reset_b", {lvl_b, rise_b, fall_b, pend_b}, 8'b10_00_00_00);
        ce = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 22; i++) begin
            d_a = tbl[i].d;
            ce  = tbl[i].ce;
            tick();
            chk($sformatf("vec%0d", i), {lvl_a, rise_a, fall_a, pend_a},
                {tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].pend});
        end

        // Reset in the middle of a qualification (ch0 cnt=2).
        ce  = 1'b1;
        d_a = 2'b01;
        repeat (4) tick();
        chk("pre_reset_pend", {lvl_a, rise_a, fall_a, pend_a}, 8'b00_00_00_01);
        #2 rst_n = 1'b0;
        d_a = 2'b00;
        #1;
        chk("mid_count_reset", {lvl_a, rise_a, fall_a, pend_a}, 8'b00_00_00_00);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("post_reset_a%0d", k), {lvl_a, rise_a, fall_a, pend_a}, 8'b00_00_00_00);
            chk($sformatf("post_reset_b%0d", k), {lvl_b, rise_b, fall_b, pend_b}, 8'b10_00_00_00);
        end

        // ce only every 4th edge: mismatch visible from edge 3, ce edges 4,8,12,16.
        d_a = 2'b01;
        for (int k = 1; k <= 18; k++) begin
            ce = ((k % 4) == 0);
            tick();
            el = (k >= 16) ? 2'b01 : 2'b00;
            er = (k == 16) ? 2'b01 : 2'b00;
            ep = (k >= 4 && k < 16) ? 2'b01 : 2'b00;
            chk($sformatf("ce_gate%0d", k), {lvl_a, rise_a, fall_a, pend_a}, {el, er, 2'b00, ep});
        end
        do_reset();

        // Bounce 1,1,0,0 then settle at 1: sy sees 1,1,0,0,1... from edge 3.
        r_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            d_a = (k <= 2 || k >= 5) ? 2'b01 : 2'b00;
            tick();
            r_cnt += int'(rise_a[0]);
            el = (k >= 10) ? 2'b01 : 2'b00;
            er = (k == 10) ? 2'b01 : 2'b00;
            ep = (k == 3 || k == 4 || (k >= 7 && k <= 9)) ? 2'b01 : 2'b00;
            chk($sformatf("bounce%0d", k), {lvl_a, rise_a, fall_a, pend_a}, {el, er, 2'b00, ep});
        end
        chk("bounce_rise_count", 8'(r_cnt), 8'd1);

        // Opposite transitions on both channels of the RST_VAL=10 instance.
        d_b = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            el = (k >= 6) ? 2'b01 : 2'b10;
            er = (k == 6) ? 2'b01 : 2'b00;
            ef = (k == 6) ? 2'b10 : 2'b00;
            ep = (k >= 3 && k <= 5) ? 2'b11 : 2'b00;
            chk($sformatf("indep%0d", k), {lvl_b, rise_b, fall_b, pend_b}, {el, er, ef, ep});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
